id_ex_stage: RTL

ID/EX pipeline register for the 32-bit datapath. It captures one decoded instruction per handshake. It produces the ALU operands `read_data1` and `Mux` and the 4-bit `ALU_control` consumed directly by the ALU. Operand forwarding from EX/MEM and MEM/WB is resolved on the stage outputs. Load-use hazards are handled by inserting a single bubble.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fwd_sel.sv | 33 +++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath definitions: ALU opcodes and the ID/EX pipeline entry layout.
package cpu_pkg;

    localparam int XLEN_W = 32;
    localparam int RW_W   = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic [XLEN_W-1:0] read_data1;
        logic [XLEN_W-1:0] read_data2;
        logic [XLEN_W-1:0] imm;
        logic              alu_src;
        logic [3:0]        alu_control;
        logic [RW_W-1:0]   rs;
        logic [RW_W-1:0]   rt;
        logic [RW_W-1:0]   dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

endpackage

// File: rtl/fwd_sel.sv
// Forward-source selection for one operand index; EX/MEM wins over MEM/WB, r0 never forwards.
module fwd_sel #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic [RW-1:0]   src,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exmem_reg_write,
    input  logic [RW-1:0]   exmem_dest,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RW-1:0]   memwb_dest,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] data
);

    logic src_nonzero_s;

    assign src_nonzero_s = (src != {RW{1'b0}});

    // Priority mux: youngest producer first, then older producer, then register file value.
    always_comb begin
        data = reg_data;
        if (exmem_reg_write && (exmem_dest == src) && src_nonzero_s) begin
            data = exmem_result;
        end else if (memwb_reg_write && (memwb_dest == src) && src_nonzero_s) begin
            data = memwb_result;
        end else begin
            data = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry handshake buffer with operand forwarding
// and one-bubble load-use hazard insertion.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_W,
    parameter int RW   = RW_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] id_read_data1,
    input  logic [XLEN-1:0] id_read_data2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_control,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_dest,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [RW-1:0]   exmem_dest,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RW-1:0]   memwb_dest,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] Mux,
    output logic [XLEN-1:0] store_data,
    output logic [3:0]      ALU_control,
    output logic [RW-1:0]   ex_dest,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            load_use_stall
);

    id_ex_t          entry_r;
    id_ex_t          entry_next_s;
    logic            valid_r;
    logic            hazard_s;
    logic            transfer_in_s;
    logic            leave_s;
    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;

    // A held load whose destination feeds the incoming instruction must drain first.
    assign hazard_s = valid_r && entry_r.mem_read && entry_r.reg_write
                   && (entry_r.dest != {RW{1'b0}}) && in_valid
                   && ((entry_r.dest == id_rs) || (entry_r.dest == id_rt));

    assign in_ready       = !flush && !hazard_s && (!valid_r || out_ready);
    assign out_valid      = valid_r && !flush;
    assign transfer_in_s  = in_valid && in_ready;
    assign leave_s        = out_valid && out_ready;
    assign load_use_stall = hazard_s;

    // Pack the decoded ID fields into the entry layout.
    always_comb begin
        entry_next_s             = {$bits(id_ex_t){1'b0}};
        entry_next_s.read_data1  = id_read_data1;
        entry_next_s.read_data2  = id_read_data2;
        entry_next_s.imm         = id_imm;
        entry_next_s.alu_src     = id_alu_src;
        entry_next_s.alu_control = id_alu_control;
        entry_next_s.rs          = id_rs;
        entry_next_s.rt          = id_rt;
        entry_next_s.dest        = id_dest;
        entry_next_s.reg_write   = id_reg_write;
        entry_next_s.mem_read    = id_mem_read;
        entry_next_s.mem_write   = id_mem_write;
        entry_next_s.mem_to_reg  = id_mem_to_reg;
    end

    // Entry state: reset, then flush, then load, then drain, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            entry_r <= {$bits(id_ex_t){1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
            entry_r <= entry_r;
        end else if (transfer_in_s) begin
            valid_r <= 1'b1;
            entry_r <= entry_next_s;
        end else if (leave_s) begin
            valid_r <= 1'b0;
            entry_r <= entry_r;
        end else begin
            valid_r <= valid_r;
            entry_r <= entry_r;
        end
    end

    fwd_sel #(.XLEN(XLEN), .RW(RW)) u_fwd_rs (
        .src             (entry_r.rs),
        .reg_data        (entry_r.read_data1),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .data            (fwd_a_s)
    );

    fwd_sel #(.XLEN(XLEN), .RW(RW)) u_fwd_rt (
        .src             (entry_r.rt),
        .reg_data        (entry_r.read_data2),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .data            (fwd_b_s)
    );

    assign read_data1    = fwd_a_s;
    assign store_data    = fwd_b_s;
    assign Mux           = entry_r.alu_src ? entry_r.imm : fwd_b_s;
    assign ALU_control   = entry_r.alu_control;
    assign ex_dest       = entry_r.dest;
    assign ex_reg_write  = entry_r.reg_write  && valid_r;
    assign ex_mem_read   = entry_r.mem_read   && valid_r;
    assign ex_mem_write  = entry_r.mem_write  && valid_r;
    assign ex_mem_to_reg = entry_r.mem_to_reg && valid_r;

endmodule
